stage_if: RTL and testbench
===========================

# stage_if

Instruction-fetch stage of the pipelined CPU, directly upstream of the decode stage. Holds the PC and runs the instruction-memory read handshake. Loads the IF/ID pipeline register with the fetched word, its PC and PC+1, which decode consumes. Honours stall/flush from the hazard logic and PC redirects from branch/jump resolution.

## Interface
- `WORD_SIZE`, 16, width of instruction/PC words.
- `RESET_PC`, 16'h0000, PC value loaded on reset.
- `clk` in 1: single clock, all state updates on rising edge.
- `reset_n` in 1: synchronous, active-high reset (1 = reset, sampled on `clk` rising edge; name kept per codebase port naming).
- `i_readM` out 1: instruction-memory read request.
- `i_address` out WORD_SIZE: fetch address (current PC).
- `i_data` in WORD_SIZE: instruction word, valid when `i_inputReady`=1.
- `i_inputReady` in 1: memory response strobe, one cycle per request.
- `stall` in 1: IF/ID must hold; PC must not advance past a captured word.
- `flush` in 1: IF/ID contents squashed next edge.
- `redirect` in 1: load PC from `redirect_pc` (taken branch/jump).
- `redirect_pc` in WORD_SIZE: redirect target.
- `ifid_valid` out 1: IF/ID holds a real instruction.
- `ifid_inst` out WORD_SIZE: fetched instruction.
- `ifid_pc` out WORD_SIZE: address of `ifid_inst`.
- `ifid_pc_next` out WORD_SIZE: `ifid_pc`+1.

## Operation
- States: FETCH, HOLD, ABORT. Reset → FETCH.
- `i_readM` = 1 only in FETCH and not in reset; `i_address` = PC (Moore, from registers).
- FETCH, `i_inputReady`=1, no redirect:
  - `stall`=0: IF/ID ← {1, `i_data`, PC, PC+1}; PC ← PC+1; stay FETCH.
  - `stall`=1: word into internal buffer (inst, PC); IF/ID unchanged; → HOLD.
- FETCH, `i_inputReady`=0: if `stall`=0, `ifid_valid` ← 0 (bubble); if `stall`=1, IF/ID holds. Request stays asserted.
- HOLD: `i_readM`=0. When `stall`=0: IF/ID ← buffer; PC ← PC+1; → FETCH.
- `redirect`=1 (any state): PC ← `redirect_pc`; any response this cycle and any buffered word discarded; `ifid_valid` ← 0; → ABORT.
- ABORT: `i_readM`=0 for exactly one cycle (drops in-flight request); → FETCH. `redirect` in ABORT reloads PC, stays ABORT one more cycle.
- `flush`=1 without redirect: `ifid_valid` ← 0 next edge; overrides `stall` for IF/ID only; fetch state/PC/buffer otherwise follow normal rules (buffered word in HOLD is kept).
- Priority: reset > redirect > flush > stall.
- PC arithmetic modulo 2^WORD_SIZE: 16'hFFFF+1 = 16'h0000; `ifid_pc_next` wraps identically.

## Timing
- Reset values: `ifid_valid`=0, `ifid_inst`=0, `ifid_pc`=0, `ifid_pc_next`=0, PC=RESET_PC, `i_readM`=0 during reset cycle, 1 in the first cycle after.
- Latency: `i_inputReady` at cycle t → `ifid_valid`=1 with that word after edge ending t.
- Back-to-back: 1-cycle memory sustains one instruction per cycle.
- Redirect at cycle t: ABORT in t+1 (`i_readM`=0), request to `redirect_pc` in t+2.
- Reset mid-fetch: pending response ignored; buffer cleared; state FETCH.
- Memory contract: `i_inputReady` only in response to asserted `i_readM`; a response arriving in ABORT/HOLD is ignored.

## Test plan
- Reset with RESET_PC=16'h0000, 1-cycle memory returning inst=addr+16'h1000 → IF/ID sequence (16'h1000,0,1),(16'h1001,1,2),(16'h1002,2,3) on consecutive cycles, `ifid_valid`=1 from second post-reset edge.
- 3-cycle memory latency → `ifid_valid` toggles 0,0,1 per instruction; PC advances only on response.
- `stall` high 4 cycles coinciding with response at PC=5 → IF/ID frozen, `i_readM`=0 in HOLD; after release IF/ID=(inst@5,5,6), next request to 6; no instruction lost/duplicated.
- `redirect`=1, `redirect_pc`=16'h0040 same cycle as response at PC=9 → word@9 dropped, `ifid_valid`=0, one cycle `i_readM`=0, then `i_address`=16'h0040, ifid_pc=16'h0040 next.
- `flush` and `stall` together with IF/ID valid → `ifid_valid`=0 next edge; PC unchanged.
- PC=16'hFFFF fetched → `ifid_pc_next`=16'h0000, next `i_address`=16'h0000; reset asserted mid-request → `i_readM`=0, PC=RESET_PC next edge.

Source files
------------

// File: rtl/stage_if.sv
// stage_if: instruction-fetch stage.
// Holds the PC, runs the instruction-memory read handshake and loads the
// IF/ID pipeline register {valid, inst, pc, pc+1} consumed by decode.
// Ports:
//   clk, reset_n        : clock, synchronous active-high reset
//   i_readM, i_address  : memory read request and fetch address (PC)
//   i_data, i_inputReady: memory response word and its strobe
//   stall, flush        : hazard control (hold IF/ID / squash IF/ID)
//   redirect, redirect_pc: taken branch/jump target load
//   ifid_*              : IF/ID pipeline register outputs
module stage_if #(
  parameter int                   WORD_SIZE = 16,
  parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  output logic                 i_readM,
  output logic [WORD_SIZE-1:0] i_address,
  input  logic [WORD_SIZE-1:0] i_data,
  input  logic                 i_inputReady,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 redirect,
  input  logic [WORD_SIZE-1:0] redirect_pc,
  output logic                 ifid_valid,
  output logic [WORD_SIZE-1:0] ifid_inst,
  output logic [WORD_SIZE-1:0] ifid_pc,
  output logic [WORD_SIZE-1:0] ifid_pc_next
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    ABORT = 2'd2
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [WORD_SIZE-1:0] r_pc, w_pc_nxt, w_pc_inc;
  logic [WORD_SIZE-1:0] r_buf, w_buf_nxt;
  logic                 r_valid, w_valid_nxt;
  logic [WORD_SIZE-1:0] r_inst, w_inst_nxt;
  logic [WORD_SIZE-1:0] r_ipc, w_ipc_nxt;
  logic [WORD_SIZE-1:0] r_ipcn, w_ipcn_nxt;
  logic                 w_load;
  logic [WORD_SIZE-1:0] w_load_inst;

  // PC arithmetic wraps modulo 2^WORD_SIZE.
  assign w_pc_inc = r_pc + WORD_SIZE'(1);

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_buf_nxt   = r_buf;
    w_valid_nxt = r_valid;
    w_inst_nxt  = r_inst;
    w_ipc_nxt   = r_ipc;
    w_ipcn_nxt  = r_ipcn;
    w_load      = 1'b0;
    w_load_inst = r_buf;

    if (redirect) begin
      // Response and buffered word are both dropped; one dead cycle follows.
      w_state_nxt = ABORT;
      w_pc_nxt    = redirect_pc;
      w_buf_nxt   = '0;
      w_valid_nxt = 1'b0;
    end else begin
      case (r_state)
        FETCH: begin
          if (i_inputReady) begin
            if (!stall) begin
              w_load      = 1'b1;
              w_load_inst = i_data;
            end else begin
              // Park the word so the PC never runs past a captured fetch.
              w_buf_nxt   = i_data;
              w_state_nxt = HOLD;
            end
          end else if (!stall) begin
            w_valid_nxt = 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            w_load      = 1'b1;
            w_load_inst = r_buf;
            w_state_nxt = FETCH;
          end
        end
        ABORT:   w_state_nxt = FETCH;
        default: w_state_nxt = FETCH;
      endcase

      // PC only advances when a word actually enters IF/ID.
      if (w_load) begin
        w_valid_nxt = 1'b1;
        w_inst_nxt  = w_load_inst;
        w_ipc_nxt   = r_pc;
        w_ipcn_nxt  = w_pc_inc;
        w_pc_nxt    = w_pc_inc;
      end

      // Flush squashes IF/ID only; fetch state, PC and buffer proceed.
      if (flush) begin
        w_valid_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n) begin
      r_state <= FETCH;
      r_pc    <= RESET_PC;
      r_buf   <= '0;
      r_valid <= 1'b0;
      r_inst  <= '0;
      r_ipc   <= '0;
      r_ipcn  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_buf   <= w_buf_nxt;
      r_valid <= w_valid_nxt;
      r_inst  <= w_inst_nxt;
      r_ipc   <= w_ipc_nxt;
      r_ipcn  <= w_ipcn_nxt;
    end
  end

  assign i_readM      = (r_state == FETCH) && !reset_n;
  assign i_address    = r_pc;
  assign ifid_valid   = r_valid;
  assign ifid_inst    = r_inst;
  assign ifid_pc      = r_ipc;
  assign ifid_pc_next = r_ipcn;

endmodule

// File: tb/tb_stage_if.sv
// tb_stage_if: self-checking bench for stage_if with a variable-latency
// instruction memory (word = address + 16'h1000) and a behavioural model.
module tb_stage_if;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        i_readM;
  logic [15:0] i_address;
  logic [15:0] i_data = '0;
  logic        i_inputReady = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        ifid_valid;
  logic [15:0] ifid_inst;
  logic [15:0] ifid_pc;
  logic [15:0] ifid_pc_next;

  stage_if #(.WORD_SIZE(16), .RESET_PC(16'h0000)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_readM      (i_readM),
    .i_address    (i_address),
    .i_data       (i_data),
    .i_inputReady (i_inputReady),
    .stall        (stall),
    .flush        (flush),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .ifid_valid   (ifid_valid),
    .ifid_inst    (ifid_inst),
    .ifid_pc      (ifid_pc),
    .ifid_pc_next (ifid_pc_next)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: architectural PC, a "word waiting on stall" slot,
  // a "dead cycle after redirect" flag, and the IF/ID contents.
  bit          m_rst;
  bit          m_valid;
  logic [15:0] m_inst, m_ipc, m_ipcn, m_pc, m_hold_inst;
  bit          m_hold, m_abort;

  // Memory model state.
  int mem_cnt = 0;
  int lat = 1;
  bit rand_lat = 0;

  logic [65:0] dut_vec;
  assign dut_vec = {ifid_valid, ifid_inst, ifid_pc, ifid_pc_next, i_readM, i_address};

  function automatic logic [65:0] exp_vec();
    logic req;
    req = !m_rst && !m_hold && !m_abort;
    return {m_valid, m_inst, m_ipc, m_ipcn, req, m_pc};
  endfunction

  // One clock cycle: drive controls, let memory respond, advance model,
  // then return 1 time unit after the rising edge.
  task automatic step(input bit rst, input bit st, input bit fl,
                      input bit rd, input logic [15:0] rpc);
    bit          deliver;
    logic [15:0] word;
    @(negedge clk);
    reset_n = rst; stall = st; flush = fl; redirect = rd; redirect_pc = rpc;
    #1;
    if (i_readM) begin
      if (mem_cnt + 1 >= lat) begin
        i_inputReady = 1'b1;
        i_data       = i_address + 16'h1000;
        mem_cnt      = 0;
        if (rand_lat) lat = $urandom_range(1, 3);
      end else begin
        i_inputReady = 1'b0;
        mem_cnt++;
      end
    end else begin
      i_inputReady = 1'b0;
      mem_cnt      = 0;
    end

    deliver = 0;
    word    = '0;
    if (rst) begin
      m_valid = 0; m_inst = '0; m_ipc = '0; m_ipcn = '0;
      m_pc = 16'h0000; m_hold = 0; m_abort = 0;
    end else if (rd) begin
      m_pc = rpc; m_hold = 0; m_abort = 1; m_valid = 0;
    end else begin
      if (m_abort) m_abort = 0;
      else if (m_hold) begin
        if (!st) begin deliver = 1; word = m_hold_inst; m_hold = 0; end
      end else if (i_inputReady) begin
        if (!st) begin deliver = 1; word = i_data; end
        else begin m_hold = 1; m_hold_inst = i_data; end
      end else if (!st) m_valid = 0;
      if (deliver) begin
        m_valid = 1; m_inst = word; m_ipc = m_pc;
        m_ipcn = m_pc + 16'd1; m_pc = m_pc + 16'd1;
      end
      if (fl) m_valid = 0;
    end
    m_rst = rst;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    lat = 1; rand_lat = 0;
    step(1, 0, 0, 0, '0);
    step(1, 0, 0, 0, '0);
    if (dut_vec !== exp_vec()) begin
      errors++; $display("FAIL reset_model got=%h want=%h", dut_vec, exp_vec());
    end
    checks++;
    if ({i_readM, ifid_valid, ifid_inst, ifid_pc, ifid_pc_next, i_address} !== 66'd0) begin
      errors++;
      $display("FAIL reset_values readM=%b valid=%b inst=%h pc=%h pcn=%h addr=%h want all 0",
               i_readM, ifid_valid, ifid_inst, ifid_pc, ifid_pc_next, i_address);
    end
    checks++;
  endtask

  task automatic test_sequential();
    logic [15:0] kk;
    lat = 1; rand_lat = 0;
    step(1, 0, 0, 0, '0);
    for (int k = 0; k < 6; k++) begin
      step(0, 0, 0, 0, '0);
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL seq_model k=%0d got=%h want=%h", k, dut_vec, exp_vec());
      end
      checks++;
      if (k < 3) begin
        kk = k[15:0];
        if ({ifid_valid, ifid_inst, ifid_pc, ifid_pc_next, i_readM} !==
            {1'b1, 16'h1000 + kk, kk, kk + 16'd1, 1'b1}) begin
          errors++;
          $display("FAIL seq_ifid k=%0d got v=%b i=%h pc=%h pcn=%h want i=%h pc=%h",
                   k, ifid_valid, ifid_inst, ifid_pc, ifid_pc_next, 16'h1000 + kk, kk);
        end
        checks++;
      end
    end
  endtask

  task automatic test_latency3();
    lat = 3; rand_lat = 0;
    step(1, 0, 0, 0, '0);
    for (int k = 0; k < 9; k++) begin
      step(0, 0, 0, 0, '0);
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL lat3_model k=%0d got=%h want=%h", k, dut_vec, exp_vec());
      end
      checks++;
      if (ifid_valid !== (k % 3 == 2) || i_address !== 16'((k + 1) / 3)) begin
        errors++;
        $display("FAIL lat3_pattern k=%0d valid=%b addr=%h want valid=%b addr=%h",
                 k, ifid_valid, i_address, (k % 3 == 2), 16'((k + 1) / 3));
      end
      checks++;
    end
  endtask

  task automatic test_stall();
    lat = 1; rand_lat = 0;
    step(1, 0, 0, 0, '0);
    for (int k = 0; k < 5; k++) step(0, 0, 0, 0, '0);
    for (int s = 0; s < 4; s++) begin
      step(0, 1, 0, 0, '0);
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL stall_model s=%0d got=%h want=%h", s, dut_vec, exp_vec());
      end
      checks++;
      if ({ifid_valid, ifid_inst, ifid_pc, i_readM, i_address} !==
          {1'b1, 16'h1004, 16'h0004, 1'b0, 16'h0005}) begin
        errors++;
        $display("FAIL stall_frozen s=%0d v=%b i=%h pc=%h readM=%b addr=%h want 1 1004 0004 0 0005",
                 s, ifid_valid, ifid_inst, ifid_pc, i_readM, i_address);
      end
      checks++;
    end
    step(0, 0, 0, 0, '0);
    if ({ifid_valid, ifid_inst, ifid_pc, ifid_pc_next, i_readM, i_address} !==
        {1'b1, 16'h1005, 16'h0005, 16'h0006, 1'b1, 16'h0006}) begin
      errors++;
      $display("FAIL stall_release got=%h want ifid=(1005,5,6) req@6", dut_vec);
    end
    checks++;
    step(0, 0, 0, 0, '0);
    if ({ifid_valid, ifid_inst, ifid_pc} !== {1'b1, 16'h1006, 16'h0006}) begin
      errors++; $display("FAIL stall_next got=%h want ifid=(1006,6)", dut_vec);
    end
    checks++;
  endtask

  task automatic test_redirect();
    lat = 1; rand_lat = 0;
    step(1, 0, 0, 0, '0);
    for (int k = 0; k < 9; k++) step(0, 0, 0, 0, '0);
    step(0, 0, 0, 1, 16'h0040);
    if ({ifid_valid, i_readM, i_address} !== {1'b0, 1'b0, 16'h0040}) begin
      errors++;
      $display("FAIL redir_abort valid=%b readM=%b addr=%h want 0 0 0040", ifid_valid, i_readM, i_address);
    end
    checks++;
    step(0, 0, 0, 0, '0);
    if ({ifid_valid, i_readM, i_address} !== {1'b0, 1'b1, 16'h0040}) begin
      errors++;
      $display("FAIL redir_req valid=%b readM=%b addr=%h want 0 1 0040", ifid_valid, i_readM, i_address);
    end
    checks++;
    step(0, 0, 0, 0, '0);
    if ({ifid_valid, ifid_inst, ifid_pc, ifid_pc_next} !== {1'b1, 16'h1040, 16'h0040, 16'h0041}) begin
      errors++; $display("FAIL redir_target got=%h want ifid=(1040,40,41)", dut_vec);
    end
    checks++;
    step(0, 0, 0, 1, 16'h0080);
    step(0, 0, 0, 1, 16'h0090);
    if ({i_readM, i_address} !== {1'b0, 16'h0090}) begin
      errors++; $display("FAIL redir_in_abort readM=%b addr=%h want 0 0090", i_readM, i_address);
    end
    checks++;
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 0, '0);
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL redir_model k=%0d got=%h want=%h", k, dut_vec, exp_vec());
      end
      checks++;
    end
  endtask

  task automatic test_flush_stall();
    lat = 1; rand_lat = 0;
    step(1, 0, 0, 0, '0);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 0, '0);
    step(0, 1, 1, 0, '0);
    if ({ifid_valid, i_readM, i_address} !== {1'b0, 1'b0, 16'h0003}) begin
      errors++;
      $display("FAIL flush_stall valid=%b readM=%b addr=%h want 0 0 0003", ifid_valid, i_readM, i_address);
    end
    checks++;
    step(0, 0, 0, 0, '0);
    if ({ifid_valid, ifid_inst, ifid_pc, i_address} !== {1'b1, 16'h1003, 16'h0003, 16'h0004}) begin
      errors++; $display("FAIL flush_buffer_kept got=%h want ifid=(1003,3) addr 0004", dut_vec);
    end
    checks++;
  endtask

  task automatic test_wrap_and_reset();
    lat = 1; rand_lat = 0;
    step(1, 0, 0, 0, '0);
    step(0, 0, 0, 1, 16'hFFFF);
    step(0, 0, 0, 0, '0);
    step(0, 0, 0, 0, '0);
    if ({ifid_valid, ifid_inst, ifid_pc, ifid_pc_next, i_address} !==
        {1'b1, 16'h0FFF, 16'hFFFF, 16'h0000, 16'h0000}) begin
      errors++; $display("FAIL wrap got=%h want ifid=(0FFF,FFFF,0000) addr 0000", dut_vec);
    end
    checks++;
    lat = 3;
    step(0, 0, 0, 0, '0);
    step(0, 0, 0, 0, '0);
    step(1, 0, 0, 0, '0);
    if ({i_readM, ifid_valid, i_address} !== {1'b0, 1'b0, 16'h0000}) begin
      errors++;
      $display("FAIL reset_mid readM=%b valid=%b addr=%h want 0 0 0000", i_readM, ifid_valid, i_address);
    end
    checks++;
    for (int k = 0; k < 3; k++) step(0, 0, 0, 0, '0);
    if ({ifid_valid, ifid_inst, ifid_pc} !== {1'b1, 16'h1000, 16'h0000}) begin
      errors++; $display("FAIL reset_mid_refetch got=%h want ifid=(1000,0)", dut_vec);
    end
    checks++;
  endtask

  task automatic test_random();
    bit rst, st, fl, rd;
    rand_lat = 1; lat = 1;
    step(1, 0, 0, 0, '0);
    for (int k = 0; k < 400; k++) begin
      rst = ($urandom_range(0, 99) == 0);
      rd  = ($urandom_range(0, 99) < 6);
      st  = ($urandom_range(0, 99) < 30);
      fl  = ($urandom_range(0, 99) < 10);
      step(rst, st, fl, rd, 16'($urandom));
      if (dut_vec !== exp_vec()) begin
        errors++; $display("FAIL random_model k=%0d got=%h want=%h", k, dut_vec, exp_vec());
      end
      checks++;
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_latency3();
    test_stall();
    test_redirect();
    test_flush_stall();
    test_wrap_and_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
